// File: rtl/ecg_acc_pkg.sv
// Shared definitions for the accelerator weight path: widths and the
// weight address sequencer state encoding.
package ecg_acc_pkg;

    localparam int unsigned WT_AW   = 11;
    localparam int unsigned NUM_COL = 8;
    localparam int unsigned KKM_W   = 9;
    localparam int unsigned REP_W   = 10;
    localparam int unsigned NT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } wag_state_e;

endpackage

// File: rtl/weight_addr_gen_if.sv
// Control, configuration and per-column read port bundle between the layer
// controller (master) and the weight address sequencer (slave).
interface weight_addr_gen_if;
    import ecg_acc_pkg::*;

    logic             start;
    logic             stall;
    logic [WT_AW-1:0] cfg_base;
    logic [KKM_W-1:0] cfg_kkm;
    logic [REP_W-1:0] cfg_rep;
    logic [NT_W-1:0]  cfg_nt;

    logic [WT_AW-1:0] wt_C0_addr, wt_C1_addr, wt_C2_addr, wt_C3_addr;
    logic [WT_AW-1:0] wt_C4_addr, wt_C5_addr, wt_C6_addr, wt_C7_addr;
    logic wt_C0_O_vld, wt_C1_O_vld, wt_C2_O_vld, wt_C3_O_vld;
    logic wt_C4_O_vld, wt_C5_O_vld, wt_C6_O_vld, wt_C7_O_vld;
    logic busy;
    logic done;

    modport master (
        output start, stall, cfg_base, cfg_kkm, cfg_rep, cfg_nt,
        input  wt_C0_addr, wt_C1_addr, wt_C2_addr, wt_C3_addr,
               wt_C4_addr, wt_C5_addr, wt_C6_addr, wt_C7_addr,
               wt_C0_O_vld, wt_C1_O_vld, wt_C2_O_vld, wt_C3_O_vld,
               wt_C4_O_vld, wt_C5_O_vld, wt_C6_O_vld, wt_C7_O_vld,
               busy, done
    );

    modport slave (
        input  start, stall, cfg_base, cfg_kkm, cfg_rep, cfg_nt,
        output wt_C0_addr, wt_C1_addr, wt_C2_addr, wt_C3_addr,
               wt_C4_addr, wt_C5_addr, wt_C6_addr, wt_C7_addr,
               wt_C0_O_vld, wt_C1_O_vld, wt_C2_O_vld, wt_C3_O_vld,
               wt_C4_O_vld, wt_C5_O_vld, wt_C6_O_vld, wt_C7_O_vld,
               busy, done
    );

endinterface

// File: rtl/weight_skew_pipe.sv
// Enable-gated diagonal skew for {valid, address}: column i is column 0
// delayed by i enabled cycles; column 0 passes straight through.
module weight_skew_pipe #(
    parameter int unsigned NUM_COL = 8,
    parameter int unsigned AW      = 11
) (
    input  logic                         clk_cal,
    input  logic                         rst_cal_n,
    input  logic                         en,
    input  logic                         in_vld,
    input  logic [AW-1:0]                in_addr,
    output logic [NUM_COL-1:0]           vld,
    output logic [NUM_COL-1:0][AW-1:0]   addr
);

    logic [NUM_COL-1:1]         vld_q;
    logic [NUM_COL-1:1][AW-1:0] addr_q;

    assign vld  = {vld_q, in_vld};
    assign addr = {addr_q, in_addr};

    always_ff @(posedge clk_cal or negedge rst_cal_n) begin
        if (!rst_cal_n) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else if (en) begin
            vld_q  <= vld[NUM_COL-2:0];
            addr_q <= addr[NUM_COL-2:0];
        end
    end

endmodule

// File: rtl/weight_addr_gen.sv
// Weight buffer read-address sequencer: walks kkm elements x rep reuses x nt
// groups and fans the column-0 stream out diagonally across the PE columns.
module weight_addr_gen #(
    parameter int unsigned WT_AW   = ecg_acc_pkg::WT_AW,
    parameter int unsigned NUM_COL = ecg_acc_pkg::NUM_COL,
    parameter int unsigned KKM_W   = ecg_acc_pkg::KKM_W
) (
    input  logic              clk_cal,
    input  logic              rst_cal_n,
    weight_addr_gen_if.slave  wif
);
    import ecg_acc_pkg::*;

    localparam int unsigned DRN_W = $clog2(NUM_COL);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(NUM_COL - 2);

    wag_state_e       state;
    logic [KKM_W-1:0] kkm_s;
    logic [REP_W-1:0] rep_s;
    logic [NT_W-1:0]  nt_s;
    logic [KKM_W-1:0] e_q;
    logic [REP_W-1:0] r_q;
    logic [NT_W-1:0]  g_q;
    logic [WT_AW-1:0] grp_base;
    logic [DRN_W-1:0] drn_q;
    logic             run_q;
    logic             busy_q;
    logic             done_q;

    logic                           cfg_zero;
    logic [WT_AW-1:0]               c0_addr;
    logic                           pipe_en;
    logic [NUM_COL-1:0]             col_vld;
    logic [NUM_COL-1:0][WT_AW-1:0]  col_addr;

    assign cfg_zero = (wif.cfg_kkm == '0) || (wif.cfg_rep == '0) || (wif.cfg_nt == '0);
    assign c0_addr  = grp_base + WT_AW'(e_q);
    assign pipe_en  = ~wif.stall;

    always_ff @(posedge clk_cal or negedge rst_cal_n) begin
        if (!rst_cal_n) begin
            state    <= ST_IDLE;
            kkm_s    <= '0;
            rep_s    <= '0;
            nt_s     <= '0;
            e_q      <= '0;
            r_q      <= '0;
            g_q      <= '0;
            grp_base <= '0;
            drn_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wif.start) begin
                        kkm_s    <= wif.cfg_kkm;
                        rep_s    <= wif.cfg_rep;
                        nt_s     <= wif.cfg_nt;
                        grp_base <= wif.cfg_base;
                        e_q      <= '0;
                        r_q      <= '0;
                        g_q      <= '0;
                        drn_q    <= '0;
                        if (cfg_zero) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            run_q  <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // e innermost, r middle, g outermost; grp_base steps by kkm per group
                    if (!wif.stall) begin
                        if (e_q == kkm_s - KKM_W'(1)) begin
                            e_q <= '0;
                            if (r_q == rep_s - REP_W'(1)) begin
                                r_q <= '0;
                                if (g_q == nt_s - NT_W'(1)) begin
                                    g_q   <= '0;
                                    state <= ST_DRAIN;
                                    run_q <= 1'b0;
                                end else begin
                                    g_q      <= g_q + NT_W'(1);
                                    grp_base <= grp_base + WT_AW'(kkm_s);
                                end
                            end else begin
                                r_q <= r_q + REP_W'(1);
                            end
                        end else begin
                            e_q <= e_q + KKM_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!wif.stall) begin
                        if (drn_q == DRN_LAST) begin
                            drn_q  <= '0;
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            drn_q <= drn_q + DRN_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    run_q  <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    weight_skew_pipe #(
        .NUM_COL (NUM_COL),
        .AW      (WT_AW)
    ) u_skew (
        .clk_cal   (clk_cal),
        .rst_cal_n (rst_cal_n),
        .en        (pipe_en),
        .in_vld    (run_q),
        .in_addr   (c0_addr),
        .vld       (col_vld),
        .addr      (col_addr)
    );

    assign wif.wt_C0_addr = col_addr[0];
    assign wif.wt_C1_addr = col_addr[1];
    assign wif.wt_C2_addr = col_addr[2];
    assign wif.wt_C3_addr = col_addr[3];
    assign wif.wt_C4_addr = col_addr[4];
    assign wif.wt_C5_addr = col_addr[5];
    assign wif.wt_C6_addr = col_addr[6];
    assign wif.wt_C7_addr = col_addr[7];

    // stalled cycles must not issue reads even though the pipe holds its valids
    assign wif.wt_C0_O_vld = col_vld[0] & ~wif.stall;
    assign wif.wt_C1_O_vld = col_vld[1] & ~wif.stall;
    assign wif.wt_C2_O_vld = col_vld[2] & ~wif.stall;
    assign wif.wt_C3_O_vld = col_vld[3] & ~wif.stall;
    assign wif.wt_C4_O_vld = col_vld[4] & ~wif.stall;
    assign wif.wt_C5_O_vld = col_vld[5] & ~wif.stall;
    assign wif.wt_C6_O_vld = col_vld[6] & ~wif.stall;
    assign wif.wt_C7_O_vld = col_vld[7] & ~wif.stall;

    assign wif.busy = busy_q;
    assign wif.done = done_q;

endmodule

// File: tb/tb_weight_addr_gen.sv
// Directed bench for weight_addr_gen: per-cycle traces of all columns are
// captured per job and compared against hand-computed sequences.
module tb_weight_addr_gen;
    import ecg_acc_pkg::*;

    localparam int NCYC = 32;

    logic clk_cal = 1'b0;
    logic rst_cal_n;

    weight_addr_gen_if wif();

    weight_addr_gen #(
        .WT_AW   (WT_AW),
        .NUM_COL (NUM_COL),
        .KKM_W   (KKM_W)
    ) dut (
        .clk_cal   (clk_cal),
        .rst_cal_n (rst_cal_n),
        .wif       (wif)
    );

    always #5 clk_cal = ~clk_cal;

    logic [WT_AW-1:0]   cur_addr [NUM_COL];
    logic [NUM_COL-1:0] cur_vld;

    assign cur_addr[0] = wif.wt_C0_addr;
    assign cur_addr[1] = wif.wt_C1_addr;
    assign cur_addr[2] = wif.wt_C2_addr;
    assign cur_addr[3] = wif.wt_C3_addr;
    assign cur_addr[4] = wif.wt_C4_addr;
    assign cur_addr[5] = wif.wt_C5_addr;
    assign cur_addr[6] = wif.wt_C6_addr;
    assign cur_addr[7] = wif.wt_C7_addr;
    assign cur_vld = {wif.wt_C7_O_vld, wif.wt_C6_O_vld, wif.wt_C5_O_vld, wif.wt_C4_O_vld,
                      wif.wt_C3_O_vld, wif.wt_C2_O_vld, wif.wt_C1_O_vld, wif.wt_C0_O_vld};

    logic [WT_AW-1:0]   addr_tr [NCYC][NUM_COL];
    logic [NUM_COL-1:0] vld_tr  [NCYC];
    logic               busy_tr [NCYC];
    logic               done_tr [NCYC];
    int                 done_k;
    int                 vcnt [NUM_COL];

    int n_tests = 0;
    int n_fail  = 0;

    int seq_ru [12] = '{10, 11, 12, 10, 11, 12, 13, 14, 15, 13, 14, 15};
    int seq_wr [4]  = '{2046, 2047, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // start pulsed in cycle k=0; cfg inputs scrambled from k=1 on
    task automatic run_job(input logic [WT_AW-1:0] base, input logic [KKM_W-1:0] kkm,
                           input logic [REP_W-1:0] rep, input logic [NT_W-1:0] nt,
                           input int stall_at, input int stall_len,
                           input int restart_at, input int reset_at);
        done_k = -1;
        for (int c = 0; c < NUM_COL; c++) vcnt[c] = 0;
        @(posedge clk_cal); #1;
        wif.cfg_base = base;
        wif.cfg_kkm  = kkm;
        wif.cfg_rep  = rep;
        wif.cfg_nt   = nt;
        wif.start    = 1'b1;
        wif.stall    = 1'b0;
        for (int k = 0; k < NCYC; k++) begin
            if (k > 0) begin
                @(posedge clk_cal); #1;
                wif.start = (k == restart_at);
                wif.stall = (k >= stall_at) && (k < stall_at + stall_len);
                rst_cal_n = (k != reset_at);
                if (k == 1) begin
                    wif.cfg_base = 11'h3A5;
                    wif.cfg_kkm  = 9'd1;
                    wif.cfg_rep  = 10'd1;
                    wif.cfg_nt   = 6'd1;
                end
            end
            @(negedge clk_cal);
            vld_tr[k]  = cur_vld;
            busy_tr[k] = wif.busy;
            done_tr[k] = wif.done;
            for (int c = 0; c < NUM_COL; c++) begin
                addr_tr[k][c] = cur_addr[c];
                if (cur_vld[c]) vcnt[c]++;
            end
            if (wif.done && done_k < 0) done_k = k;
        end
        wif.start = 1'b0;
        wif.stall = 1'b0;
        rst_cal_n = 1'b1;
    endtask

    initial begin
        rst_cal_n    = 1'b0;
        wif.start    = 1'b0;
        wif.stall    = 1'b0;
        wif.cfg_base = '0;
        wif.cfg_kkm  = '0;
        wif.cfg_rep  = '0;
        wif.cfg_nt   = '0;
        repeat (3) @(posedge clk_cal);
        #1 rst_cal_n = 1'b1;
        @(negedge clk_cal);
        check("rst_vld", 32'(cur_vld), 32'd0);
        for (int c = 0; c < NUM_COL; c++) check($sformatf("rst_addr_c%0d", c), 32'(cur_addr[c]), 32'd0);
        check("rst_busy", 32'(wif.busy), 32'd0);
        check("rst_done", 32'(wif.done), 32'd0);

        // basic: 0,1,2,3
        run_job(11'd0, 9'd4, 10'd1, 6'd1, -1, 0, -1, -1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("basic_c0_k%0d", k), {vld_tr[k][0], addr_tr[k][0]}, {1'b1, 11'(k - 1)});
            check($sformatf("basic_c7_k%0d", k + 7), {vld_tr[k+7][7], addr_tr[k+7][7]}, {1'b1, 11'(k - 1)});
        end
        for (int c = 0; c < NUM_COL; c++) begin
            check($sformatf("basic_first_c%0d", c), {vld_tr[c][c], vld_tr[c+1][c], addr_tr[c+1][c]},
                  {1'b0, 1'b1, 11'd0});
            check($sformatf("basic_cnt_c%0d", c), 32'(vcnt[c]), 32'd4);
        end
        check("basic_c0_k5_vld", 32'(vld_tr[5][0]), 32'd0);
        check("basic_done_k", 32'(done_k), 32'd12);
        check("basic_busy", {busy_tr[0], busy_tr[1], busy_tr[11], busy_tr[12], done_tr[13]}, 5'b01100);

        // reuse + groups, with a second start at k=5 that must be ignored
        run_job(11'd10, 9'd3, 10'd2, 6'd2, -1, 0, 5, -1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("ru_c0_k%0d", i + 1), {vld_tr[i+1][0], addr_tr[i+1][0]}, {1'b1, 11'(seq_ru[i])});
            check($sformatf("ru_c3_k%0d", i + 4), {vld_tr[i+4][3], addr_tr[i+4][3]}, {1'b1, 11'(seq_ru[i])});
        end
        for (int c = 0; c < NUM_COL; c++) check($sformatf("ru_cnt_c%0d", c), 32'(vcnt[c]), 32'd12);
        check("ru_done_k", 32'(done_k), 32'd20);

        // address wrap
        run_job(11'd2046, 9'd4, 10'd1, 6'd1, -1, 0, -1, -1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr_c0_k%0d", i + 1), {vld_tr[i+1][0], addr_tr[i+1][0]}, {1'b1, 11'(seq_wr[i])});
            check($sformatf("wr_c5_k%0d", i + 6), {vld_tr[i+6][5], addr_tr[i+6][5]}, {1'b1, 11'(seq_wr[i])});
        end
        check("wr_done_k", 32'(done_k), 32'd12);

        // stall for cycles 3 and 4
        run_job(11'd0, 9'd4, 10'd1, 6'd1, 3, 2, -1, -1);
        check("st_c0_k2", {vld_tr[2][0], addr_tr[2][0]}, {1'b1, 11'd1});
        check("st_c0_k3", {vld_tr[3][0], addr_tr[3][0]}, {1'b0, 11'd2});
        check("st_c0_k4", {vld_tr[4][0], addr_tr[4][0]}, {1'b0, 11'd2});
        check("st_c0_k5", {vld_tr[5][0], addr_tr[5][0]}, {1'b1, 11'd2});
        check("st_c0_k6", {vld_tr[6][0], addr_tr[6][0]}, {1'b1, 11'd3});
        check("st_c1_k3", {vld_tr[3][1], addr_tr[3][1]}, {1'b0, 11'd1});
        check("st_vld_k34", {vld_tr[3], vld_tr[4]}, 16'd0);
        check("st_c7_k10", {vld_tr[10][7], addr_tr[10][7]}, {1'b1, 11'd0});
        check("st_c7_k13", {vld_tr[13][7], addr_tr[13][7]}, {1'b1, 11'd3});
        for (int c = 0; c < NUM_COL; c++) check($sformatf("st_cnt_c%0d", c), 32'(vcnt[c]), 32'd4);
        check("st_done_k", 32'(done_k), 32'd14);

        // zero-length job
        run_job(11'd7, 9'd0, 10'd3, 6'd2, -1, 0, -1, -1);
        check("z_done_k", 32'(done_k), 32'd1);
        begin
            int nb;
            int nv;
            nb = 0;
            nv = 0;
            for (int k = 0; k < NCYC; k++) if (busy_tr[k]) nb++;
            for (int c = 0; c < NUM_COL; c++) nv += vcnt[c];
            check("z_busy_cycles", 32'(nb), 32'd0);
            check("z_valids", 32'(nv), 32'd0);
        end

        // reset mid-run at k=3, then a clean rerun
        run_job(11'd5, 9'd4, 10'd1, 6'd1, -1, 0, -1, 3);
        check("rr_k3_vld", 32'(vld_tr[3]), 32'd0);
        check("rr_k3_busy", 32'(busy_tr[3]), 32'd0);
        for (int c = 0; c < NUM_COL; c++) check($sformatf("rr_k3_addr_c%0d", c), 32'(addr_tr[3][c]), 32'd0);
        check("rr_c7_cnt", 32'(vcnt[7]), 32'd0);
        check("rr_no_done", 32'(done_k), 32'hFFFF_FFFF);
        run_job(11'd5, 9'd4, 10'd1, 6'd1, -1, 0, -1, -1);
        for (int k = 1; k <= 4; k++)
            check($sformatf("rr2_c0_k%0d", k), {vld_tr[k][0], addr_tr[k][0]}, {1'b1, 11'(k + 4)});
        check("rr2_c7_cnt", 32'(vcnt[7]), 32'd4);
        check("rr2_done_k", 32'(done_k), 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
